// File: rtl/regtest_stim_pkg.sv
// Shared types and helpers for the regtest_stim stimulus/response monitor.
// FSM state encoding, LFSR feedback mask and signature fold function.
package regtest_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    // Rotate left by one, then fold the result byte into the low bits.
    function automatic logic [31:0] sig_update(input logic [31:0] sig, input logic [7:0] led);
        return {sig[30:0], sig[31]} ^ {24'h0, led};
    endfunction

endpackage

// File: rtl/regtest_stim_lfsr32.sv
// 32-bit Galois right-shift LFSR with synchronous load of SEED and step enable.
module lfsr32 #(
    parameter logic [31:0] MASK = 32'h8020_0003,
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_load,
    input  logic        i_step,
    output logic [31:0] o_value
);

    logic [31:0] r_state;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= SEED;
        end else if (i_step) begin
            r_state <= (r_state >> 1) ^ (r_state[0] ? MASK : 32'h0);
        end
    end

    assign o_value = r_state;

endmodule

// File: rtl/regtest_stim.sv
// Stimulus generator and response signature monitor for the register-file stress core.
// Optional 16-entry sampled-led log enabled by REGTEST_STIM_LED_LOG_EN.
module regtest_stim
    import regtest_stim_pkg::*;
#(
    parameter int          PERIOD     = 3,
    parameter logic [31:0] SEED       = 32'h0000_0001,
    parameter int          ITERATIONS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic [7:0]  i_led,
`ifdef REGTEST_STIM_LED_LOG_EN
    input  logic [3:0]  i_log_addr,
    output logic [7:0]  o_log_data,
`endif
    output logic [31:0] o_instr,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_signature,
    output logic [15:0] o_iter_count
);

    localparam int              PH_W      = $clog2(PERIOD);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(PERIOD - 1);
    localparam logic [15:0]     ITER_LAST = 16'(ITERATIONS - 1);

    state_t          r_state;
    logic [PH_W-1:0] r_ph;
    logic            r_smp_pend;
    logic            r_busy;
    logic            r_done;
    logic [31:0]     r_sig;
    logic [15:0]     r_iter;

    logic            w_wend;
    logic            w_load;
    logic            w_step;
    logic            w_sample;
    logic [31:0]     w_lfsr;

    assign w_wend   = (r_ph == PH_LAST);
    assign w_load   = (r_state == ST_ARM) && w_wend;
    // The final RUN window holds the LFSR so instr stays put through DRAIN/DONE.
    assign w_step   = (r_state == ST_RUN) && w_wend && (r_iter != ITER_LAST);
    assign w_sample = (r_ph == '0) && r_smp_pend;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ph <= '0;
        end else if (w_wend) begin
            r_ph <= '0;
        end else begin
            r_ph <= r_ph + 1'b1;
        end
    end

    lfsr32 #(
        .MASK (LFSR_MASK),
        .SEED (SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_load  (w_load),
        .i_step  (w_step),
        .o_value (w_lfsr)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= ST_IDLE;
            r_smp_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sig      <= '0;
            r_iter     <= '0;
        end else begin
            // A RUN window's led result is sampled at the first edge of the next window.
            if (w_wend) r_smp_pend <= (r_state == ST_RUN);
            if (w_sample) r_sig <= sig_update(r_sig, i_led);
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_state <= ST_ARM;
                    r_busy  <= 1'b1;
                end
                ST_ARM: if (w_wend) begin
                    r_state <= ST_RUN;
                    r_sig   <= '0;
                    r_iter  <= '0;
                end
                ST_RUN: if (w_wend) begin
                    r_iter <= r_iter + 16'd1;
                    if (r_iter == ITER_LAST) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                ST_DONE: if (i_start) begin
                    r_state <= ST_ARM;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef REGTEST_STIM_LED_LOG_EN
    logic [7:0] r_log [16];
    logic [3:0] r_wptr;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wptr <= '0;
            for (int i = 0; i < 16; i++) r_log[i] <= '0;
        end else if (w_load) begin
            r_wptr <= '0;
        end else if (w_sample) begin
            r_log[r_wptr] <= i_led;
            r_wptr        <= r_wptr + 4'd1;
        end
    end

    assign o_log_data = r_log[i_log_addr];
`endif

    assign o_instr      = w_lfsr;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_signature  = r_sig;
    assign o_iter_count = r_iter;

endmodule

// File: tb/tb_regtest_stim.sv
// Directed bench for regtest_stim: reset values, window timing, signatures, start/reset behaviour.
// Instance A runs ITERATIONS=2, instance B ITERATIONS=1; log instance only with REGTEST_STIM_LED_LOG_EN.
module tb_regtest_stim;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [7:0]  led_a = 8'h5A, led_b = 8'h5A;
    logic [31:0] instr_a, instr_b, sig_a, sig_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [15:0] iter_a, iter_b;
    int          cyc;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // Posedges since reset release; edge k ends phase (k-1) % 3.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

`ifdef REGTEST_STIM_LED_LOG_EN
    logic [3:0]  la_a = '0, la_b = '0, la_c = '0;
    logic [7:0]  ld_a, ld_b, ld_c;
    logic        start_c = 1'b0;
    logic [31:0] instr_c, sig_c;
    logic        busy_c, done_c;
    logic [15:0] iter_c;
    logic [7:0]  led_c;
    // Window k's sample equals k, since iter_count has just reached k.
    assign led_c = iter_c[7:0];

    regtest_stim #(.ITERATIONS(20)) u_dut_c (
        .i_clk(clk), .i_rstn(rstn), .i_start(start_c), .i_led(led_c),
        .i_log_addr(la_c), .o_log_data(ld_c),
        .o_instr(instr_c), .o_busy(busy_c), .o_done(done_c),
        .o_signature(sig_c), .o_iter_count(iter_c));
`endif

    regtest_stim #(.ITERATIONS(2)) u_dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_start(start_a), .i_led(led_a),
`ifdef REGTEST_STIM_LED_LOG_EN
        .i_log_addr(la_a), .o_log_data(ld_a),
`endif
        .o_instr(instr_a), .o_busy(busy_a), .o_done(done_a),
        .o_signature(sig_a), .o_iter_count(iter_a));

    regtest_stim #(.ITERATIONS(1)) u_dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_start(start_b), .i_led(led_b),
`ifdef REGTEST_STIM_LED_LOG_EN
        .i_log_addr(la_b), .o_log_data(ld_b),
`endif
        .o_instr(instr_b), .o_busy(busy_b), .o_done(done_b),
        .o_signature(sig_b), .o_iter_count(iter_b));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // First window boundary strictly after the start edge s, then the run length.
    function automatic int exp_done(input int s, input int iters);
        int e = s + 1;
        while ((e - 1) % 3 != 2) e++;
        return e + iters * 3 + 1;
    endfunction

    function automatic int exp_exit(input int s);
        int e = s + 1;
        while ((e - 1) % 3 != 2) e++;
        return e;
    endfunction

    task automatic pulse_start(input int which, output int s);
        @(negedge clk);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
`ifdef REGTEST_STIM_LED_LOG_EN
            default: start_c = 1'b1;
`else
            default: ;
`endif
        endcase
        s = cyc + 1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
`ifdef REGTEST_STIM_LED_LOG_EN
        start_c = 1'b0;
`endif
    endtask

    task automatic wait_done(input int which, input string tag, output int dc);
        logic d;
        dc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            case (which)
                0: d = done_a;
                1: d = done_b;
`ifdef REGTEST_STIM_LED_LOG_EN
                default: d = done_c;
`else
                default: d = 1'b0;
`endif
            endcase
            if (d) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int s, dc, ex;

        repeat (3) @(negedge clk);
        chk("rst_instr", instr_a, 32'h1);
        chk("rst_sig",   sig_a,   32'h0);
        chk("rst_busy",  {31'd0, busy_a}, 32'd0);
        chk("rst_done",  {31'd0, done_a}, 32'd0);
        chk("rst_iter",  {16'd0, iter_a}, 32'd0);
        rstn = 1'b1;

        // Idle for a few cycles: nothing moves without start.
        repeat (3) @(negedge clk);
        chk("idle_busy",  {31'd0, busy_a}, 32'd0);
        chk("idle_instr", instr_a, 32'h1);

        // Run A, ITERATIONS=2, led=5A.
        pulse_start(0, s);
        chk("arm_busy", {31'd0, busy_a}, 32'd1);
        ex = exp_exit(s);
        while (cyc < ex + 1) @(negedge clk);
        chk("win1_instr", instr_a, 32'h1);
        while (cyc < ex + 4) @(negedge clk);
        chk("win2_instr", instr_a, 32'h8020_0003);
        wait_done(0, "a1", dc);
        chk("a1_done_cyc", dc, ex + 7);
        chk("a1_sig",   sig_a, 32'h0000_00EE);
        chk("a1_iter",  {16'd0, iter_a}, 32'd2);
        chk("a1_busy",  {31'd0, busy_a}, 32'd0);
        chk("a1_instr", instr_a, 32'h8020_0003);

        // Run B, ITERATIONS=1, led=5A.
        pulse_start(1, s);
        wait_done(1, "b1", dc);
        chk("b1_done_cyc", dc, exp_done(s, 1));
        chk("b1_sig", sig_b, 32'h0000_005A);

        // Restart A from DONE with led=FF: FF, then rot(FF)^FF = 101.
        led_a = 8'hFF;
        pulse_start(0, s);
        chk("a2_done_clr", {31'd0, done_a}, 32'd0);
        wait_done(0, "a2", dc);
        chk("a2_done_cyc", dc, exp_done(s, 2));
        chk("a2_sig", sig_a, 32'h0000_0101);

        // Same run with a stray start pulse mid-RUN.
        pulse_start(0, s);
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, "a3", dc);
        chk("a3_done_cyc", dc, exp_done(s, 2));
        chk("a3_sig", sig_a, 32'h0000_0101);

        // Reset in the middle of RUN, in window 2 after its first sample.
        led_a = 8'h5A;
        pulse_start(0, s);
        ex = exp_exit(s);
        while (cyc < ex + 5) @(negedge clk);
        chk("mid_iter", {16'd0, iter_a}, 32'd1);
        chk("mid_sig",  sig_a, 32'h0000_005A);
        #2 rstn = 1'b0;
        #1;
        chk("arst_instr", instr_a, 32'h1);
        chk("arst_sig",   sig_a,   32'h0);
        chk("arst_busy",  {31'd0, busy_a}, 32'd0);
        chk("arst_done",  {31'd0, done_a}, 32'd0);
        chk("arst_iter",  {16'd0, iter_a}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        pulse_start(0, s);
        wait_done(0, "a4", dc);
        chk("a4_done_cyc", dc, exp_done(s, 2));
        chk("a4_sig", sig_a, 32'h0000_00EE);

`ifdef REGTEST_STIM_LED_LOG_EN
        pulse_start(2, s);
        wait_done(2, "c", dc);
        chk("c_done_cyc", dc, exp_done(s, 20));
        for (int i = 0; i < 16; i++) begin
            la_c = 4'(i);
            #1;
            chk($sformatf("log%0d", i), {24'd0, ld_c}, (i < 4) ? 32'(17 + i) : 32'(i + 1));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
